// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with level, threshold flags and error pulses.
// Optional FIFO_FWFT_EN selects first-word fall-through read data; default is registered read.
`default_nettype none

module sync_fifo_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic                  rinc,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int              c_DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] c_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

  logic [ADDR_WIDTH:0] r_wptr;
  logic [ADDR_WIDTH:0] r_rptr;
  logic [ADDR_WIDTH:0] r_level;
  logic                r_full;
  logic                r_empty;
  logic                r_afull;
  logic                r_aempty;
  logic                r_ovf;
  logic                r_unf;

  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [ADDR_WIDTH:0] w_wptr_nxt;
  logic [ADDR_WIDTH:0] w_rptr_nxt;
  logic [ADDR_WIDTH:0] w_level_nxt;

  // Acceptance uses the registered flags, i.e. the state before the edge.
  assign w_wr_acc    = winc && !r_full;
  assign w_rd_acc    = rinc && !r_empty;
  assign w_wptr_nxt  = r_wptr + {{ADDR_WIDTH{1'b0}}, w_wr_acc};
  assign w_rptr_nxt  = r_rptr + {{ADDR_WIDTH{1'b0}}, w_rd_acc};
  assign w_level_nxt = w_wptr_nxt - w_rptr_nxt;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr[ADDR_WIDTH-1:0]] <= writeData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_level  <= w_level_nxt;
      r_full   <= (w_wptr_nxt == {~w_rptr_nxt[ADDR_WIDTH], w_rptr_nxt[ADDR_WIDTH-1:0]});
      r_empty  <= (w_wptr_nxt == w_rptr_nxt);
      r_afull  <= (w_level_nxt >= c_AFULL);
      r_aempty <= (w_level_nxt <= c_AEMPTY);
      r_ovf    <= winc && r_full;
      r_unf    <= rinc && r_empty;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head entry is visible combinationally; forced to zero while empty so reset reads clean.
  assign readData = r_empty ? '0 : r_mem[r_rptr[ADDR_WIDTH-1:0]];
`else
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_acc) begin
      r_rdata <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
    end
  end

  assign readData = r_rdata;
`endif

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign level        = r_level;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param (default and small configurations).
`default_nettype none

module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default configuration
  logic       winc = 1'b0, rinc = 1'b0;
  logic [7:0] wd = '0, rd;
  logic       full, empty, af, ae, ovf, unf;
  logic [4:0] lvl;

  // Small configuration: 16-bit, 4 entries
  logic        winc1 = 1'b0, rinc1 = 1'b0;
  logic [15:0] wd1 = '0, rd1;
  logic        full1, empty1, af1, ae1, ovf1, unf1;
  logic [2:0]  lvl1;

  int errors = 0;
  int checks = 0;

  sync_fifo_param u_dut (
    .clk(clk), .rst(rst), .winc(winc), .rinc(rinc), .writeData(wd), .readData(rd),
    .full(full), .empty(empty), .almost_full(af), .almost_empty(ae), .level(lvl),
    .overflow(ovf), .underflow(unf)
  );

  sync_fifo_param #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .AFULL_THRESH(3), .AEMPTY_THRESH(0)) u_dut1 (
    .clk(clk), .rst(rst), .winc(winc1), .rinc(rinc1), .writeData(wd1), .readData(rd1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1), .level(lvl1),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop one word from the default FIFO and check the returned data in either read mode.
  task automatic pop_chk(input string tag, input logic [7:0] exp);
    rinc = 1'b1;
`ifdef FIFO_FWFT_EN
    chk(tag, 32'(rd), 32'(exp));
`endif
    tick();
`ifndef FIFO_FWFT_EN
    chk(tag, 32'(rd), 32'(exp));
`endif
    rinc = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(ae), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(af), 0);
    chk("rst_level", 32'(lvl), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_unf", 32'(unf), 0);
    chk("rst_rdata", 32'(rd), 0);
    chk("rst1_empty", 32'(empty1), 1);
    rst = 1'b0;
    tick();

    // Mid-stream async reset at level 5
    for (int i = 0; i < 6; i++) begin
      winc = 1'b1; wd = 8'hA0 + 8'(i); tick();
    end
    winc = 1'b0;
    pop_chk("mid_pop", 8'hA0);
    chk("mid_level5", 32'(lvl), 5);
    #2 rst = 1'b1;
    #1;
    chk("async_empty", 32'(empty), 1);
    chk("async_level", 32'(lvl), 0);
    chk("async_full", 32'(full), 0);
    chk("async_rdata", 32'(rd), 0);
    @(posedge clk); #1 rst = 1'b0;
    tick();

    // Fill 16 words, then one extra write
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; wd = 8'h12 + 8'(i); tick();
      chk("fill_level", 32'(lvl), 32'(i + 1));
      chk("fill_afull", 32'(af), 32'((i + 1) >= 12));
      chk("fill_full", 32'(full), 32'((i + 1) == 16));
    end
    wd = 8'h99; tick();
    chk("ovf_pulse", 32'(ovf), 1);
    chk("ovf_level", 32'(lvl), 16);
    winc = 1'b0; tick();
    chk("ovf_clear", 32'(ovf), 0);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      pop_chk("drain_data", 8'h12 + 8'(i));
      chk("drain_level", 32'(lvl), 32'(15 - i));
      chk("drain_aempty", 32'(ae), 32'((15 - i) <= 2));
      chk("drain_empty", 32'(empty), 32'(i == 15));
    end
    rinc = 1'b1; tick(); rinc = 1'b0;
    chk("unf_pulse", 32'(unf), 1);
    chk("unf_level", 32'(lvl), 0);
    tick();
    chk("unf_clear", 32'(unf), 0);
`ifndef FIFO_FWFT_EN
    chk("rdata_hold", 32'(rd), 32'h21);
`endif

    // Simultaneous traffic at level 8 across pointer wrap
    for (int i = 0; i < 8; i++) begin
      winc = 1'b1; wd = 8'h40 + 8'(i); tick();
    end
    for (int i = 0; i < 20; i++) begin
      winc = 1'b1; wd = 8'h48 + 8'(i);
      pop_chk("simul_data", 8'h40 + 8'(i));
      chk("simul_level", 32'(lvl), 8);
    end
    winc = 1'b0;
    for (int i = 0; i < 8; i++) pop_chk("simul_tail", 8'h54 + 8'(i));
    chk("simul_empty", 32'(empty), 1);

    // Both requests while full
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; wd = 8'h60 + 8'(i); tick();
    end
    chk("bfull_full", 32'(full), 1);
    wd = 8'hEE;
    pop_chk("bfull_data", 8'h60);
    winc = 1'b0;
    chk("bfull_level", 32'(lvl), 15);
    chk("bfull_ovf", 32'(ovf), 1);
    chk("bfull_notfull", 32'(full), 0);
    for (int i = 1; i < 16; i++) pop_chk("bfull_drain", 8'h60 + 8'(i));
    chk("bfull_empty", 32'(empty), 1);

    // Both requests while empty
    winc = 1'b1; rinc = 1'b1; wd = 8'h77; tick();
    winc = 1'b0; rinc = 1'b0;
    chk("bempty_level", 32'(lvl), 1);
    chk("bempty_unf", 32'(unf), 1);
    chk("bempty_notempty", 32'(empty), 0);
    pop_chk("bempty_data", 8'h77);
    chk("bempty_level0", 32'(lvl), 0);

    // Small configuration: 4 entries, thresholds 3 / 0
    for (int i = 0; i < 4; i++) begin
      winc1 = 1'b1; wd1 = (i == 0) ? 16'hA5C3 : 16'(16'h1111 * i); tick();
      chk("p_level", 32'(lvl1), 32'(i + 1));
      chk("p_afull", 32'(af1), 32'((i + 1) >= 3));
      chk("p_aempty", 32'(ae1), 0);
      chk("p_full", 32'(full1), 32'(i == 3));
    end
    winc1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rinc1 = 1'b1;
`ifdef FIFO_FWFT_EN
      chk("p_data", 32'(rd1), (i == 0) ? 32'hA5C3 : 32'(16'h1111 * i));
`endif
      tick();
`ifndef FIFO_FWFT_EN
      chk("p_data", 32'(rd1), (i == 0) ? 32'hA5C3 : 32'(16'h1111 * i));
`endif
      chk("p_drain_aempty", 32'(ae1), 32'(i == 3));
    end
    rinc1 = 1'b0;
    chk("p_empty", 32'(empty1), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
